// File: rtl/dibit_packer.sv
// dibit_packer
//   Packs decoded 2-bit symbols {x,y} into bytes. Completed bytes are
//   buffered in a small first-word-fall-through FIFO. A flush pulse zero-pads
//   and emits a partial byte at frame end.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   decoded symbol present
//   in_x       symbol bit 1
//   in_y       symbol bit 0
//   in_ready   packer can accept a symbol this cycle (state-only)
//   flush      single-cycle request to emit the partial byte
//   out_valid  FIFO head valid
//   out_data   FIFO head byte (0 when empty)
//   out_ready  consumer takes the head this cycle
//   out_count  bytes currently buffered
module dibit_packer #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_x,
  input  logic                     in_y,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_EMPTY      = 2'd0,
    S_ACCUM      = 2'd1,
    S_FLUSH_PEND = 2'd2
  } state_t;

  // Position a symbol in its byte slot; unused slots stay zero (padding).
  function automatic logic [7:0] place_sym(input logic [1:0] sym, input logic [1:0] slot);
    logic [7:0] r;
    if (MSB_FIRST) begin
      r = {sym, 6'd0} >> {slot, 1'b0};
    end else begin
      r = {6'd0, sym} << {slot, 1'b0};
    end
    return r;
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      sym_cnt_r;
  logic [1:0]      sym_cnt_s;
  logic [7:0]      shift_r;
  logic [7:0]      shift_s;
  logic [7:0]      merged_s;
  logic            accept_s;
  logic            push_s;
  logic [7:0]      push_data_s;
  logic            pop_s;
  logic            fifo_full_s;

  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  // Full flag comes from the registered count only, so nothing here depends
  // combinationally on out_ready.
  assign fifo_full_s = (count_r == CW'(DEPTH));
  assign in_ready    = (state_r != S_FLUSH_PEND) && !((sym_cnt_r == 2'd3) && fifo_full_s);
  assign accept_s    = in_valid && in_ready;
  assign merged_s    = shift_r | place_sym({in_x, in_y}, sym_cnt_r);
  assign pop_s       = (count_r != {CW{1'b0}}) && out_ready;

  assign out_valid   = (count_r != {CW{1'b0}});
  assign out_data    = out_valid ? mem_r[rd_ptr_r] : 8'd0;
  assign out_count   = count_r;

  // Packer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_EMPTY;
      sym_cnt_r <= 2'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_s;
      sym_cnt_r <= sym_cnt_s;
      shift_r   <= shift_s;
    end
  end

  // Next-state and push decision. A symbol arriving with flush is merged
  // first; the flush then applies only if a partial byte remains.
  always_comb begin
    state_s     = state_r;
    sym_cnt_s   = sym_cnt_r;
    shift_s     = shift_r;
    push_s      = 1'b0;
    push_data_s = 8'd0;
    case (state_r)
      S_EMPTY, S_ACCUM: begin
        if (accept_s && (sym_cnt_r == 2'd3)) begin
          push_s      = 1'b1;
          push_data_s = merged_s;
          shift_s     = 8'd0;
          sym_cnt_s   = 2'd0;
          state_s     = S_EMPTY;
        end else if (accept_s && flush) begin
          if (!fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = merged_s;
            shift_s     = 8'd0;
            sym_cnt_s   = 2'd0;
            state_s     = S_EMPTY;
          end else begin
            shift_s   = merged_s;
            sym_cnt_s = sym_cnt_r + 2'd1;
            state_s   = S_FLUSH_PEND;
          end
        end else if (accept_s) begin
          shift_s   = merged_s;
          sym_cnt_s = sym_cnt_r + 2'd1;
          state_s   = S_ACCUM;
        end else if (flush && (state_r == S_ACCUM)) begin
          if (!fifo_full_s) begin
            push_s      = 1'b1;
            push_data_s = shift_r;
            shift_s     = 8'd0;
            sym_cnt_s   = 2'd0;
            state_s     = S_EMPTY;
          end else begin
            state_s = S_FLUSH_PEND;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_FLUSH_PEND: begin
        // Further flush pulses are ignored while waiting for space.
        if (!fifo_full_s) begin
          push_s      = 1'b1;
          push_data_s = shift_r;
          shift_s     = 8'd0;
          sym_cnt_s   = 2'd0;
          state_s     = S_EMPTY;
        end else begin
          state_s = S_FLUSH_PEND;
        end
      end
      default: begin
        state_s   = S_EMPTY;
        sym_cnt_s = 2'd0;
        shift_s   = 8'd0;
      end
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dibit_packer.sv
module tb_dibit_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_x, in_y, flush, out_ready;
  logic          in_ready_m, in_ready_l;
  logic          out_valid_m, out_valid_l;
  logic [7:0]    out_data_m, out_data_l;
  logic [CW-1:0] out_count_m, out_count_l;

  int checks = 0;
  int errors = 0;

  // Reference model: pending symbols, pending-flush flag, expected byte queues.
  int   sym_q[$];
  int   qm[$];
  int   ql[$];
  bit   pend_flush;

  always #5 clk = ~clk;

  dibit_packer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_ready(in_ready_m), .flush(flush), .out_valid(out_valid_m),
    .out_data(out_data_m), .out_ready(out_ready), .out_count(out_count_m));

  dibit_packer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_ready(in_ready_l), .flush(flush), .out_valid(out_valid_l),
    .out_data(out_data_l), .out_ready(out_ready), .out_count(out_count_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol k weight: MSB-first byte = s0*64+s1*16+s2*4+s3; LSB-first mirrors it.
  function automatic int pack_bytes(input bit msb);
    int b = 0;
    for (int k = 0; k < sym_q.size(); k++) begin
      if (msb) b += sym_q[k] * (1 << (6 - 2 * k));
      else     b += sym_q[k] * (1 << (2 * k));
    end
    return b;
  endfunction

  function automatic bit model_in_ready();
    return !pend_flush && !((sym_q.size() == 3) && (qm.size() == DEPTH));
  endfunction

  task automatic model_push();
    qm.push_back(pack_bytes(1'b1));
    ql.push_back(pack_bytes(1'b0));
    sym_q.delete();
  endtask

  // Advance the model by one clock edge using the current input values.
  task automatic model_edge();
    bit full_before;
    bit acc;
    if (!rst_n) begin
      sym_q.delete(); qm.delete(); ql.delete(); pend_flush = 1'b0;
      return;
    end
    full_before = (qm.size() == DEPTH);
    acc = in_valid && model_in_ready();
    if (out_ready && qm.size() != 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (pend_flush) begin
      if (!full_before) begin
        model_push();
        pend_flush = 1'b0;
      end
    end else begin
      if (acc) sym_q.push_back({30'd0, in_x, in_y});
      if (sym_q.size() == 4) begin
        model_push();
      end else if (flush && sym_q.size() != 0) begin
        if (!full_before) model_push();
        else pend_flush = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready_m",  {31'd0, in_ready_m},  {31'd0, model_in_ready()});
    chk("in_ready_l",  {31'd0, in_ready_l},  {31'd0, model_in_ready()});
    chk("out_valid_m", {31'd0, out_valid_m}, {31'd0, qm.size() != 0});
    chk("out_count_m", 32'(out_count_m),     32'(qm.size()));
    chk("out_count_l", 32'(out_count_l),     32'(ql.size()));
    chk("out_data_m",  {24'd0, out_data_m},  (qm.size() != 0) ? 32'(qm[0]) : 32'd0);
    chk("out_data_l",  {24'd0, out_data_l},  (ql.size() != 0) ? 32'(ql[0]) : 32'd0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic sym(input logic x, input logic y);
    in_valid = 1'b1; in_x = x; in_y = y;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = 1'b0; in_y = 1'b0;
    flush = 1'b0; out_ready = 1'b0; pend_flush = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready_m},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data_m},  32'd0);
    chk("rst_out_count", 32'(out_count_m),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, both placements.
    out_ready = 1'b1;
    sym(1'b1, 1'b0); sym(1'b0, 1'b1); sym(1'b1, 1'b1); sym(1'b0, 1'b0);
    chk("byte_msb", {24'd0, out_data_m}, 32'h9C);
    chk("byte_lsb", {24'd0, out_data_l}, 32'h36);
    chk("byte_valid", {31'd0, out_valid_m}, 32'd1);
    cycle();
    chk("byte_count0", 32'(out_count_m), 32'd0);

    // Partial byte + flush, then flush while empty.
    out_ready = 1'b0;
    sym(1'b1, 1'b1); sym(1'b0, 1'b1);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_msb", {24'd0, out_data_m}, 32'hD0);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_empty", 32'(out_count_m), 32'd0);

    // Backpressure: fill FIFO and stall with three pending symbols.
    for (int i = 0; i < 4 * DEPTH + 3; i++) sym(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("full_count", 32'(out_count_m), 32'(DEPTH));
    chk("full_in_ready", {31'd0, in_ready_m}, 32'd0);
    in_valid = 1'b1; in_x = 1'b1; in_y = 1'b0;
    cycle(); cycle();
    out_ready = 1'b1;
    cycle();
    chk("resume_in_ready", {31'd0, in_ready_m}, 32'd1);
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      in_x = 1'($urandom_range(0, 1)); in_y = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 1'b0;
    drain();

    // Flush with FIFO full and two pending symbols.
    out_ready = 1'b0;
    for (int i = 0; i < 4 * DEPTH + 2; i++) sym(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("fp_in_ready_before", {31'd0, in_ready_m}, 32'd1);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("fp_in_ready", {31'd0, in_ready_m}, 32'd0);
    flush = 1'b1; cycle(); flush = 1'b0;
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    cycle();
    chk("fp_count", 32'(out_count_m), 32'(DEPTH));
    chk("fp_in_ready_after", {31'd0, in_ready_m}, 32'd1);
    drain();

    // Asynchronous reset mid-byte with two bytes buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) sym(1'b1, 1'b1);
    chk("pre_rst_count", 32'(out_count_m), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid_m}, 32'd0);
    chk("arst_out_count", 32'(out_count_m),     32'd0);
    chk("arst_in_ready",  {31'd0, in_ready_m},  32'd1);
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    sym(1'b0, 1'b0); sym(1'b0, 1'b0); sym(1'b0, 1'b0); sym(1'b1, 1'b1);
    chk("post_rst_byte", {24'd0, out_data_m}, 32'h03);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = 1'($urandom_range(0, 1));
      in_y      = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 4) < 3);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dibit_packer.md
Name: dibit_packer

Overview:
- Downstream stage of the 4-input/2-output symbol decoder.
- Each cycle it may accept one decoded 2-bit symbol {x,y}. It packs four symbols into a byte and buffers completed bytes in a small first-word-fall-through FIFO.
- Bytes leave on a valid/ready interface toward the byte-wide consumer.
- A flush input zero-pads and emits a partial byte at frame end.

Parameters:
- DEPTH, 4, output FIFO depth in bytes; power of two, >= 2.
- MSB_FIRST, 1:
  - 1: first symbol of a byte lands in bits [7:6].
  - 0: first symbol lands in bits [1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decoded symbol present.
- in_x  input  1  symbol bit 1 (decoder x).
- in_y  input  1  symbol bit 0 (decoder y).
- in_ready  output  1  packer can accept a symbol this cycle.
- flush  input  1  single-cycle request to emit the partial byte.
- out_valid  output  1  FIFO head valid.
- out_data  output  8  FIFO head byte.
- out_ready  input  1  consumer takes head this cycle.
- out_count  output  $clog2(DEPTH)+1  bytes currently buffered.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low via rst_n.
- Reset values: sym_cnt=0, shift register=0, FIFO empty, flush_pend=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0.
- Reset mid-operation discards the partial byte and all buffered bytes. No output handshake completes on the reset cycle.
- Symbol accept: on in_valid && in_ready. Symbol value = {in_x,in_y}.
  - sym_cnt counts 0..3 and wraps 3->0 when the 4th symbol is accepted.
  - The completed byte is pushed into the FIFO on that same edge.
- Placement:
  - MSB_FIRST=1: symbol k (k=0..3) goes to bits [7-2k:6-2k].
  - MSB_FIRST=0: symbol k goes to bits [2k+1:2k].
- in_ready is a registered/state-only function with no combinational path from out_ready:
  - in_ready = !flush_pend && !(sym_cnt==3 && fifo_full).
- State machine:
  - EMPTY (sym_cnt=0, no pending flush).
  - ACCUM (sym_cnt 1..3).
  - FLUSH_PEND.
- Transitions:
  - EMPTY->ACCUM on accept.
  - ACCUM->EMPTY on 4th accept.
  - ACCUM->EMPTY on flush with FIFO not full: pushes the padded byte.
  - ACCUM->FLUSH_PEND on flush with FIFO full.
  - FLUSH_PEND->EMPTY on the first cycle FIFO is not full (evaluated on registered count): pushes the padded byte.
  - flush in EMPTY: no effect, no byte emitted.
- Padding: unused symbol slots are 0.
- Simultaneous flush + accept in the same cycle:
  - The symbol is included first, then the flush is applied.
  - If that symbol completes the byte, only the full byte is pushed; the flush has no further effect.
  - If FIFO space is insufficient, the cycle is treated as a flush in the FIFO-full case.
- flush asserted while FLUSH_PEND is ignored.
- FIFO behaviour:
  - First-word fall-through: out_valid = count!=0; out_data = head entry, 0 when empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed: count unchanged, pointers wrap modulo DEPTH.
  - A push never occurs when full, and a pop never occurs when empty.
- Latency: the byte-completing accept or executed flush at edge N gives out_valid=1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput: 1 symbol/cycle sustained when out_ready is held high.
- Output stability: out_data and out_valid are stable while out_valid && !out_ready.

Test Plan:
- Reset then stream (1,0),(0,1),(1,1),(0,0) with MSB_FIRST=1, out_ready=1 -> out_valid for one cycle after the 4th accept, out_data=0x9C, out_count returns to 0.
- Same stream with MSB_FIRST=0 -> out_data=0x36.
- Accept (1,1),(0,1), flush pulse -> out_data=0xD0, sym_cnt back to 0. A following flush in EMPTY emits nothing.
- Hold out_ready=0, stream 4*DEPTH+3 symbols -> out_count=DEPTH and in_ready=0 with sym_cnt=3.
  - Then raise out_ready: bytes drain in order, in_ready returns the cycle after the first pop, and no symbol is lost or duplicated.
- FIFO full with sym_cnt=2, pulse flush -> in_ready=0 (FLUSH_PEND). One pop -> padded byte pushed, out_count stays DEPTH, in_ready=1.
- Assert rst_n=0 asynchronously mid-byte with out_count=2 -> out_valid=0, out_count=0, in_ready=1 immediately.
  - After release, 4 symbols (0,0)x3,(1,1) -> 0x03 (MSB_FIRST=1).
